// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from several requesters into one uart_tx,
// with optional grant locking for multi-byte messages and a start-handshake timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int TIMEOUT_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_busy,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic [2:0]           grant_id,
  output logic                 err_timeout,
  output logic [15:0]          byte_count
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   tick_cnt;
  logic               lock_active;
  logic               sel_vld;
  logic [2:0]         sel_id;
  logic               accept;
  logic               timeout_hit;
  logic               frame_done;
  logic [7:0]         valid_pad;
  logic [7:0]         lock_pad;
  logic [63:0]        data_pad;

  // Requester vectors padded to the 3-bit index space so indexing is exact.
  assign valid_pad = 8'(req_valid);
  assign lock_pad  = 8'(req_lock);
  assign data_pad  = 64'(req_data);

  function automatic logic [2:0] wrap_idx(input logic [3:0] raw);
    return (raw >= 4'(NUM_REQ)) ? 3'(raw - 4'(NUM_REQ)) : raw[2:0];
  endfunction

  // Locked requester wins while it still has data; otherwise the nearest set
  // bit after the last grant wins (loop runs far-to-near so nearest is last).
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = grant_id;
    if (lock_active && valid_pad[grant_id]) begin
      sel_vld = 1'b1;
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        if (valid_pad[wrap_idx({1'b0, grant_id} + 4'(k))]) begin
          sel_vld = 1'b1;
          sel_id  = wrap_idx({1'b0, grant_id} + 4'(k));
        end
      end
    end
  end

  assign accept      = (state == IDLE) && sel_vld;
  assign timeout_hit = (state == WAIT_BUSY) && !tx_busy && clk_en &&
                       (tick_cnt == CNT_W'(TIMEOUT_TICKS - 1));
  assign frame_done  = (state == WAIT_DONE) && !tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = LAUNCH;
      LAUNCH:    if (clk_en && !tx_busy) state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)          state_nxt = WAIT_DONE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // req_ready is gated by rst_n so it drops the instant reset asserts.
  always_comb begin
    req_ready   = '0;
    tx_start    = 1'b0;
    err_timeout = 1'b0;
    if (rst_n && accept) req_ready = NUM_REQ'(1) << sel_id;
    if (state == LAUNCH && clk_en && !tx_busy) tx_start = 1'b1;
    if (timeout_hit) err_timeout = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt    <= '0;
      tx_data     <= 8'h00;
      grant_id    <= 3'(NUM_REQ - 1);
      lock_active <= 1'b0;
      byte_count  <= 16'h0000;
    end else begin
      if (state == WAIT_BUSY) begin
        if (clk_en) tick_cnt <= tick_cnt + CNT_W'(1);
      end else begin
        tick_cnt <= '0;
      end

      if (accept) begin
        tx_data     <= data_pad[{sel_id, 3'b000} +: 8];
        grant_id    <= sel_id;
        lock_active <= lock_pad[sel_id];
      end else if (state == IDLE && lock_active && !valid_pad[grant_id]) begin
        lock_active <= 1'b0;
      end else if (timeout_hit) begin
        lock_active <= 1'b0;
      end

      if (frame_done) byte_count <= byte_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter against a transaction-level
// model of grant order, lock behaviour, start/timeout timing and frame count.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, tx_busy;
  logic [3:0]  req_valid, req_lock, req_ready;
  logic [31:0] req_data;
  logic        tx_start, err_timeout;
  logic [7:0]  tx_data;
  logic [2:0]  grant_id;
  logic [15:0] byte_count;

  int          checks = 0;
  int          errors = 0;

  int          m_last;
  bit          m_lock;
  logic [15:0] m_count;
  logic [7:0]  m_data;

  logic [3:0]  rv, rl;
  logic [31:0] rd;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
    .req_ready(req_ready), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_data(tx_data), .grant_id(grant_id), .err_timeout(err_timeout),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    clk_en = ($urandom_range(0, 1) == 1);
  endtask

  task automatic scramble();
    req_valid = 4'($urandom);
    req_data  = $urandom;
    req_lock  = 4'($urandom);
  endtask

  task automatic model_reset();
    m_last  = N - 1;
    m_lock  = 1'b0;
    m_count = 16'h0000;
    m_data  = 8'h00;
  endtask

  function automatic bit has(input logic [3:0] v, input int i);
    return ((v >> i) & 4'b0001) != 4'b0000;
  endfunction

  function automatic int model_pick(input logic [3:0] v);
    if (m_lock && has(v, m_last)) return m_last;
    for (int k = 1; k <= N; k++)
      if (has(v, (m_last + k) % N)) return (m_last + k) % N;
    return -1;
  endfunction

  task automatic check_quiet();
    chk("req_ready_quiet", 32'(req_ready), 32'd0);
    chk("tx_data_hold", 32'(tx_data), 32'(m_data));
    chk("grant_id_hold", 32'(grant_id), 32'(m_last));
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_grant_id", 32'(grant_id), 32'(N - 1));
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'h0000);
  endtask

  task automatic do_reset();
    cyc(); rst_n = 1'b0; tx_busy = 1'b0; req_valid = 4'hF; #1;
    check_reset_vals();
    cyc(); rst_n = 1'b1; req_valid = 4'h0;
    model_reset();
  endtask

  task automatic idle_cycle();
    cyc(); req_valid = 4'h0; req_data = $urandom; tx_busy = 1'b0; #1;
    m_lock = 1'b0;
    chk("idle_req_ready", 32'(req_ready), 32'd0);
    chk("idle_tx_start", 32'(tx_start), 32'd0);
    chk("idle_err", 32'(err_timeout), 32'd0);
    chk("idle_byte_count", 32'(byte_count), 32'(m_count));
    chk("idle_tx_data", 32'(tx_data), 32'(m_data));
    chk("idle_grant_id", 32'(grant_id), 32'(m_last));
  endtask

  // mode 0: normal frame, 1: uart never goes busy, 2: reset during WAIT_DONE
  task automatic frame(input int mode, output int sel);
    int ticks, d, h;
    bit done, exp_bit;
    cyc(); req_valid = rv; req_data = rd; req_lock = rl; tx_busy = 1'b0; #1;
    if (m_lock && !has(rv, m_last)) m_lock = 1'b0;
    sel = model_pick(rv);
    chk("byte_count", 32'(byte_count), 32'(m_count));
    chk("tx_data_prev", 32'(tx_data), 32'(m_data));
    chk("idle_tx_start", 32'(tx_start), 32'd0);
    chk("idle_err", 32'(err_timeout), 32'd0);
    if (sel < 0) begin
      chk("req_ready_none", 32'(req_ready), 32'd0);
      return;
    end
    chk("req_ready", 32'(req_ready), 32'(1) << sel);
    m_last = sel;
    m_lock = has(rl, sel);
    m_data = 8'(rd >> (8 * sel));

    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      cyc(); scramble(); tx_busy = ($urandom_range(0, 3) == 0); #1;
      exp_bit = clk_en && !tx_busy;
      chk("tx_start", 32'(tx_start), 32'(exp_bit));
      chk("launch_err", 32'(err_timeout), 32'd0);
      check_quiet();
      done = exp_bit;
    end
    chk("launch_seen", 32'(done), 32'd1);

    ticks = 0;
    done  = 1'b0;
    d = (mode == 1) ? 1000 : int'($urandom_range(0, TO - 1));
    for (int n = 0; n < 60 && !done; n++) begin
      cyc(); scramble(); tx_busy = (ticks >= d); #1;
      exp_bit = !tx_busy && clk_en && (ticks == TO - 1);
      chk("err_timeout", 32'(err_timeout), 32'(exp_bit));
      chk("tx_start_wait", 32'(tx_start), 32'd0);
      check_quiet();
      if (tx_busy || exp_bit) done = 1'b1;
      if (clk_en) ticks++;
    end
    chk("wait_busy_resolved", 32'(done), 32'd1);
    if (mode == 1) begin
      m_lock = 1'b0;
      return;
    end

    h = $urandom_range(1, 4);
    for (int n = 0; n <= h; n++) begin
      cyc(); scramble(); tx_busy = (n < h); #1;
      chk("done_err", 32'(err_timeout), 32'd0);
      chk("done_tx_start", 32'(tx_start), 32'd0);
      check_quiet();
      if (mode == 2) begin
        #1 rst_n = 1'b0;
        #1 check_reset_vals();
        model_reset();
        return;
      end
    end
    m_count = m_count + 16'd1;
  endtask

  int s;
  int seq034 [5] = '{2, 2, 2, 3, 0};

  initial begin
    rst_n = 1'b0; clk_en = 1'b0; tx_busy = 1'b0;
    req_valid = 4'h0; req_data = 32'h0; req_lock = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset_vals();
    do_reset();

    // single requester, byte 0x55
    rv = 4'b0001; rd = 32'h0000_0055; rl = 4'h0;
    frame(0, s);
    chk("t032_sel", 32'(s), 32'd0);
    idle_cycle();
    chk("t032_data", 32'(tx_data), 32'h55);
    chk("t032_count", 32'(byte_count), 32'd1);

    // all requesters valid, no lock: rotate from requester 0
    do_reset();
    rv = 4'b1111; rl = 4'h0;
    for (int i = 0; i < 5; i++) begin
      rd = $urandom;
      frame(0, s);
      chk("t033_order", 32'(s), 32'(i % 4));
    end

    // requester 2 locks for three bytes while 0 and 3 wait
    rv = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      rl = (i < 2) ? 4'b0100 : 4'b0000;
      rd = $urandom;
      frame(0, s);
      chk("t034_order", 32'(s), 32'(seq034[i]));
    end

    // uart never busy: timeout, lock dropped, count unchanged
    rv = 4'b0010; rl = 4'b0010; rd = $urandom;
    frame(1, s);
    rv = 4'b0011; rl = 4'h0; rd = $urandom;
    frame(0, s);
    chk("t035_lock_cleared", 32'(s), 32'd0);

    // reset in the middle of WAIT_DONE
    rv = 4'b0100; rl = 4'h0; rd = $urandom;
    frame(2, s);
    cyc(); rst_n = 1'b1; tx_busy = 1'b0; req_valid = 4'h0; #1;
    check_reset_vals();
    idle_cycle();
    idle_cycle();
    rv = 4'b0010; rd = $urandom;
    frame(0, s);
    chk("t036_sel", 32'(s), 32'd1);
    idle_cycle();

    // byte_count wrap
    cyc(); req_valid = 4'h0; tx_busy = 1'b0;
    force dut.byte_count = 16'hFFFF;
    #1 release dut.byte_count;
    #1;
    m_count = 16'hFFFF;
    m_lock  = 1'b0;
    chk("t037_preload", 32'(byte_count), 32'h0000_FFFF);
    rv = 4'b1000; rd = $urandom;
    frame(0, s);
    idle_cycle();
    chk("t037_wrap", 32'(byte_count), 32'h0000_0000);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      rv = 4'($urandom_range(0, 15));
      rd = $urandom;
      rl = 4'($urandom) & 4'($urandom);
      frame(($urandom_range(0, 7) == 0) ? 1 : 0, s);
    end
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
